// File: rtl/imm_loader.sv
// Immediate-operand source for the scheduler: latches the short immediate or
// fetches a little-endian 16-bit immediate, then serves it as NSHIFT-bit slices.
//
// state     | meaning
// S_IDLE    | no instruction; slice outputs are not meaningful
// S_SHORT   | short immediate latched, slices available
// S_LOAD_LO | waiting for the low immediate byte from prefetch
// S_LOAD_HI | waiting for the high immediate byte from prefetch
// S_FULL    | 16-bit immediate complete, slices available
module imm_loader #(
  parameter int NSHIFT     = 2,
  parameter int IMM_BITS   = 16,
  parameter int SHORT_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inst_start_i,
  input  logic [SHORT_BITS-1:0] short_imm_i,
  input  logic                  inst_done_i,
  input  logic                  load_imm16_i,
  output logic                  imm16_loaded_o,
  input  logic [7:0]            pf_data_i,
  input  logic                  pf_valid_i,
  output logic                  pf_ready_o,
  input  logic                  next_imm_data_i,
  input  logic                  rewind_i,
  output logic [NSHIFT-1:0]     imm_data_out_o,
  output logic                  busy_o
);

  localparam int NSLICE = IMM_BITS / NSHIFT;
  localparam int PTR_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NSLICE - 1);

  if ((IMM_BITS % 8) != 0 || (IMM_BITS % NSHIFT) != 0 || IMM_BITS < 16 ||
      SHORT_BITS > IMM_BITS) begin : g_bad_params
    $error("imm_loader: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHORT,
    S_LOAD_LO,
    S_LOAD_HI,
    S_FULL
  } state_e;

  state_e              state_q, state_d;
  logic [IMM_BITS-1:0] imm_q, imm_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                loading;
  logic                serving;
  logic                load_start;
  logic                pf_fire;

  assign loading    = (state_q == S_LOAD_LO) || (state_q == S_LOAD_HI);
  assign serving    = (state_q == S_SHORT) || (state_q == S_FULL);
  assign load_start = ((state_q == S_IDLE) || (state_q == S_SHORT)) && load_imm16_i;
  // Reset blocks the handshake in its own cycle so no byte is swallowed.
  assign pf_fire    = loading && pf_valid_i && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      imm_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      imm_q   <= imm_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    imm_d   = imm_q;
    ptr_d   = ptr_q;

    // A byte accepted on the handshake is kept even if the load is aborted.
    if (pf_fire) begin
      if (state_q == S_LOAD_LO) begin
        imm_d = (imm_q & ~IMM_BITS'(8'hFF)) | IMM_BITS'(pf_data_i);
      end else begin
        imm_d = (imm_q & IMM_BITS'(16'h00FF)) | (IMM_BITS'(pf_data_i) << 8);
      end
    end

    if (inst_start_i) begin
      state_d = S_SHORT;
      imm_d   = IMM_BITS'(short_imm_i);
      ptr_d   = '0;
    end else if (inst_done_i) begin
      state_d = S_IDLE;
      ptr_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_SHORT: if (load_imm16_i) state_d = S_LOAD_LO;
        S_LOAD_LO:       if (pf_fire) state_d = S_LOAD_HI;
        S_LOAD_HI:       if (pf_fire) state_d = S_FULL;
        default:         state_d = state_q;
      endcase

      if (rewind_i || load_start) begin
        ptr_d = '0;
      end else if (serving && next_imm_data_i) begin
        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    pf_ready_o     = loading && !reset;
    imm16_loaded_o = (state_q == S_LOAD_HI) && pf_fire && !inst_start_i;
    busy_o         = loading;
    imm_data_out_o = imm_q[int'(ptr_q) * NSHIFT +: NSHIFT];
  end

endmodule

// File: tb/tb_imm_loader.sv
// Directed bench for imm_loader: short immediate, 16-bit fetch, stalls,
// rewind, aborts and mid-load reset, with hand-computed slice values.
module tb_imm_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       inst_start;
  logic [7:0] short_imm;
  logic       inst_done;
  logic       load_imm16;
  logic       imm16_loaded;
  logic [7:0] pf_data;
  logic       pf_valid;
  logic       pf_ready;
  logic       next_imm_data;
  logic       rewind;
  logic [1:0] imm_data_out;
  logic       busy;

  int errors = 0;
  int checks = 0;

  imm_loader #(.NSHIFT(2), .IMM_BITS(16), .SHORT_BITS(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_start_i    (inst_start),
    .short_imm_i     (short_imm),
    .inst_done_i     (inst_done),
    .load_imm16_i    (load_imm16),
    .imm16_loaded_o  (imm16_loaded),
    .pf_data_i       (pf_data),
    .pf_valid_i      (pf_valid),
    .pf_ready_o      (pf_ready),
    .next_imm_data_i (next_imm_data),
    .rewind_i        (rewind),
    .imm_data_out_o  (imm_data_out),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_inst(input logic [7:0] imm);
    short_imm  = imm;
    inst_start = 1'b1;
    step();
    inst_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; inst_start = 0; short_imm = 0; inst_done = 0; load_imm16 = 0;
    pf_data = 0; pf_valid = 0; next_imm_data = 0; rewind = 0;
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (imm16_loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded got=%0b want=0", imm16_loaded); end
    checks++; if (pf_ready !== 1'b0) begin errors++; $display("FAIL reset_pf_ready got=%0b want=0", pf_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (imm_data_out !== 2'd0) begin errors++; $display("FAIL reset_data got=%0d want=0", imm_data_out); end
  endtask

  task automatic test_short();
    logic [1:0] exp_s [8];
    exp_s = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
    start_inst(8'h5A);
    #1;
    checks++; if (pf_ready !== 1'b0) begin errors++; $display("FAIL short_pf_ready got=%0b want=0", pf_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy got=%0b want=0", busy); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (imm_data_out !== exp_s[i]) begin
        errors++; $display("FAIL short_slice%0d got=%0d want=%0d", i, imm_data_out, exp_s[i]);
      end
      next_imm_data = 1'b1; step(); next_imm_data = 1'b0; #1;
    end
    checks++; if (imm_data_out !== 2'd2) begin errors++; $display("FAIL short_wrap got=%0d want=2", imm_data_out); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_s [8];
    int ready_cnt = 0;
    int pulse_cnt = 0;
    exp_s = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
    start_inst(8'hFF);
    load_imm16 = 1'b1; #1;
    checks++; if (pf_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_early got=%0b want=0", pf_ready); end
    ready_cnt += int'(pf_ready); pulse_cnt += int'(imm16_loaded);
    step();
    pf_valid = 1'b1; pf_data = 8'h34; #1;
    checks++; if (imm_data_out !== 2'd3) begin errors++; $display("FAIL b2b_not_cleared got=%0d want=3", imm_data_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_lo got=%0b want=1", busy); end
    checks++; if (imm16_loaded !== 1'b0) begin errors++; $display("FAIL b2b_loaded_lo got=%0b want=0", imm16_loaded); end
    ready_cnt += int'(pf_ready); pulse_cnt += int'(imm16_loaded);
    step();
    pf_data = 8'h12; #1;
    checks++; if (imm16_loaded !== 1'b1) begin errors++; $display("FAIL b2b_loaded_hi got=%0b want=1", imm16_loaded); end
    ready_cnt += int'(pf_ready); pulse_cnt += int'(imm16_loaded);
    step();
    pf_valid = 1'b0; load_imm16 = 1'b0; #1;
    ready_cnt += int'(pf_ready); pulse_cnt += int'(imm16_loaded);
    step(); #1;
    ready_cnt += int'(pf_ready); pulse_cnt += int'(imm16_loaded);
    checks++; if (ready_cnt !== 2) begin errors++; $display("FAIL b2b_ready_cycles got=%0d want=2", ready_cnt); end
    checks++; if (pulse_cnt !== 1) begin errors++; $display("FAIL b2b_pulses got=%0d want=1", pulse_cnt); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (imm_data_out !== exp_s[i % 8]) begin
        errors++; $display("FAIL b2b_slice%0d got=%0d want=%0d", i, imm_data_out, exp_s[i % 8]);
      end
      next_imm_data = 1'b1; step(); next_imm_data = 1'b0; #1;
    end
  endtask

  task automatic test_stall_and_hold();
    logic [1:0] exp_s [8];
    exp_s = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1};
    start_inst(8'h00);
    load_imm16 = 1'b1; step();
    pf_valid = 1'b1; pf_data = 8'h34; step();
    pf_valid = 1'b0; next_imm_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (pf_ready !== 1'b1) begin errors++; $display("FAIL stall%0d_ready got=%0b want=1", i, pf_ready); end
      checks++; if (imm16_loaded !== 1'b0) begin errors++; $display("FAIL stall%0d_loaded got=%0b want=0", i, imm16_loaded); end
      step();
    end
    next_imm_data = 1'b0; pf_valid = 1'b1; pf_data = 8'h56; #1;
    checks++; if (imm16_loaded !== 1'b1) begin errors++; $display("FAIL stall_loaded got=%0b want=1", imm16_loaded); end
    step();
    pf_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (pf_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_ready got=%0b want=0", i, pf_ready); end
      checks++; if (imm16_loaded !== 1'b0) begin errors++; $display("FAIL hold%0d_loaded got=%0b want=0", i, imm16_loaded); end
      step();
    end
    load_imm16 = 1'b0; #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (imm_data_out !== exp_s[i]) begin
        errors++; $display("FAIL stall_slice%0d got=%0d want=%0d", i, imm_data_out, exp_s[i]);
      end
      next_imm_data = 1'b1; step(); next_imm_data = 1'b0; #1;
    end
  endtask

  task automatic test_rewind();
    next_imm_data = 1'b1; step(); step(); next_imm_data = 1'b0; #1;
    checks++; if (imm_data_out !== 2'd3) begin errors++; $display("FAIL rew_ptr2 got=%0d want=3", imm_data_out); end
    rewind = 1'b1; step(); rewind = 1'b0; #1;
    checks++; if (imm_data_out !== 2'd0) begin errors++; $display("FAIL rew_alone got=%0d want=0", imm_data_out); end
    next_imm_data = 1'b1;
    for (int i = 0; i < 5; i++) step();
    next_imm_data = 1'b0; #1;
    checks++; if (imm_data_out !== 2'd1) begin errors++; $display("FAIL rew_ptr5 got=%0d want=1", imm_data_out); end
    rewind = 1'b1; next_imm_data = 1'b1; step(); rewind = 1'b0; next_imm_data = 1'b0; #1;
    checks++; if (imm_data_out !== 2'd0) begin errors++; $display("FAIL rew_wins got=%0d want=0", imm_data_out); end
  endtask

  task automatic test_done_abort();
    start_inst(8'hAA);
    load_imm16 = 1'b1; step();
    pf_valid = 1'b1; pf_data = 8'h77; step();
    pf_valid = 1'b0; inst_done = 1'b1; #1;
    checks++; if (imm16_loaded !== 1'b0) begin errors++; $display("FAIL abort_loaded got=%0b want=0", imm16_loaded); end
    step();
    inst_done = 1'b0; load_imm16 = 1'b0; #1;
    checks++; if (pf_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%0b want=0", pf_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0b want=0", busy); end
    checks++; if (imm_data_out !== 2'd3) begin errors++; $display("FAIL abort_partial got=%0d want=3", imm_data_out); end
    next_imm_data = 1'b1; step(); next_imm_data = 1'b0; #1;
    checks++; if (imm_data_out !== 2'd3) begin errors++; $display("FAIL idle_next got=%0d want=3", imm_data_out); end
  endtask

  task automatic test_done_final_byte();
    load_imm16 = 1'b1; step();
    pf_valid = 1'b1; pf_data = 8'hCD; #1;
    checks++; if (pf_ready !== 1'b1) begin errors++; $display("FAIL fin_ready_lo got=%0b want=1", pf_ready); end
    step();
    pf_data = 8'hAB; inst_done = 1'b1; #1;
    checks++; if (imm16_loaded !== 1'b1) begin errors++; $display("FAIL fin_loaded got=%0b want=1", imm16_loaded); end
    step();
    pf_valid = 1'b0; inst_done = 1'b0; load_imm16 = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fin_busy got=%0b want=0", busy); end
    checks++; if (pf_ready !== 1'b0) begin errors++; $display("FAIL fin_ready got=%0b want=0", pf_ready); end
    checks++; if (imm_data_out !== 2'd1) begin errors++; $display("FAIL fin_data got=%0d want=1", imm_data_out); end
  endtask

  task automatic test_reset_midload();
    start_inst(8'h3C);
    load_imm16 = 1'b1; step();
    reset = 1'b1; load_imm16 = 1'b0; pf_valid = 1'b1; pf_data = 8'hEE; step();
    reset = 1'b0; #1;
    checks++; if (pf_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%0b want=0", pf_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b want=0", busy); end
    checks++; if (imm16_loaded !== 1'b0) begin errors++; $display("FAIL rst_loaded got=%0b want=0", imm16_loaded); end
    checks++; if (imm_data_out !== 2'd0) begin errors++; $display("FAIL rst_data got=%0d want=0", imm_data_out); end
    step(); #1;
    checks++; if (pf_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_later got=%0b want=0", pf_ready); end
    pf_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_short();
    test_back_to_back();
    test_stall_and_hold();
    test_rewind();
    test_done_abort();
    test_done_final_byte();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
